// File: rtl/accel_poller_pkg.sv
// Shared constants and state encoding for the ADXL362 Wishbone poller.
// Register offsets match the simple_spi wrapper decode on adr[5:3].
package accel_poller_pkg;

   localparam logic [31:0] SPCR_OFS = 32'h00;
   localparam logic [31:0] SPSR_OFS = 32'h08;
   localparam logic [31:0] SPDR_OFS = 32'h10;
   localparam logic [31:0] SPER_OFS = 32'h18;
   localparam logic [31:0] SSR_OFS  = 32'h20;

   localparam logic [7:0] SPCR_INIT   = 8'h50;
   localparam logic [7:0] ADXL_CMD_RD = 8'h0B;
   localparam logic [7:0] ADXL_XDATA  = 8'h08;

   localparam int RFEMPTY = 0;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_WAIT,
      ST_CS_ON,
      ST_TX,
      ST_POLL,
      ST_RX,
      ST_CS_OFF,
      ST_PUB
   } state_t;

   // Burst-read frame: command, start address, then three dummy bytes.
   function automatic logic [7:0] tx_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    tx_byte = ADXL_CMD_RD;
         3'd1:    tx_byte = ADXL_XDATA;
         default: tx_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/wbm_single_xfer.sv
// One classic Wishbone single cycle per start pulse; done pulses the cycle
// after ack with the low read byte captured in rdat.
module wbm_single_xfer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] adr,
   input  logic [7:0]  wdat,
   input  logic        we,
   output logic        done,
   output logic [7:0]  rdat,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i
);

   logic       cyc_q;
   logic [7:0] wdat_q;
   logic       unused_dat;

   assign unused_dat = ^wbm_dat_i[31:8];
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = cyc_q;
   assign wbm_sel_o  = cyc_q ? 4'b0001 : 4'b0000;
   assign wbm_dat_o  = {24'h000000, wdat_q};

   // ack is only honoured while a cycle is open; start is ignored while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q     <= 1'b0;
         wdat_q    <= 8'h00;
         wbm_adr_o <= 32'h0;
         wbm_we_o  <= 1'b0;
         done      <= 1'b0;
         rdat      <= 8'h00;
      end else begin
         done <= 1'b0;
         if (cyc_q) begin
            if (wbm_ack_i) begin
               cyc_q <= 1'b0;
               done  <= 1'b1;
               rdat  <= wbm_dat_i[7:0];
            end
         end else if (start) begin
            cyc_q     <= 1'b1;
            wbm_adr_o <= adr;
            wdat_q    <= wdat;
            wbm_we_o  <= we;
         end
      end
   end

endmodule

// File: rtl/wb_accel_poller.sv
// Wishbone master that configures simple_spi and periodically burst-reads ADXL362 X/Y/Z.
// Optional 4-frame averaging is built when ACCEL_POLL_AVG_EN is defined.
module wb_accel_poller
   import accel_poller_pkg::*;
#(
   parameter int unsigned PERIOD_CYC = 100000,
   parameter int unsigned POLL_LIMIT = 1024,
   parameter logic [31:0] BASE_ADR   = 32'h0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable_i,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i,
   output logic [7:0]  x_o,
   output logic [7:0]  y_o,
   output logic [7:0]  z_o,
   output logic        sample_valid_o,
   output logic        busy_o,
   output logic        timeout_o
);

   localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int PW = $clog2(POLL_LIMIT + 1);

   state_t          state, state_n;
   logic            launched, launched_n;
   logic            start;
   logic [31:0]     req_off;
   logic [7:0]      req_wdat;
   logic            req_we;
   logic            done;
   logic [7:0]      rdat;
   logic            bus_state;
   logic            poll_timeout;
   logic            pub_go;

   logic [1:0]      init_step;
   logic [2:0]      idx;
   logic [PW-1:0]   poll_cnt;
   logic            tmo_flag;
   logic [7:0]      hx, hy, hz;
   logic [CW-1:0]   period_cnt;

   wbm_single_xfer u_xfer (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .start     (start),
      .adr       (BASE_ADR + req_off),
      .wdat      (req_wdat),
      .we        (req_we),
      .done      (done),
      .rdat      (rdat),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_ack_i (wbm_ack_i)
   );

   assign poll_timeout = rdat[RFEMPTY] && (poll_cnt == PW'(POLL_LIMIT - 1));
   assign pub_go       = (state == ST_CS_OFF) && (state_n == ST_PUB);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= ST_INIT;
         launched <= 1'b0;
      end else begin
         state    <= state_n;
         launched <= launched_n;
      end
   end

   // Every bus state launches exactly one transfer, then waits for its done pulse.
   always_comb begin
      state_n    = state;
      launched_n = launched;
      start      = 1'b0;
      req_off    = SPCR_OFS;
      req_wdat   = 8'h00;
      req_we     = 1'b1;
      bus_state  = (state != ST_WAIT) && (state != ST_PUB);

      case (state)
         ST_INIT: begin
            case (init_step)
               2'd0: begin
                  req_off  = SPCR_OFS;
                  req_wdat = SPCR_INIT;
               end
               2'd1:    req_off = SPER_OFS;
               default: req_off = SSR_OFS;
            endcase
         end
         ST_CS_ON: begin
            req_off  = SSR_OFS;
            req_wdat = 8'h01;
         end
         ST_TX: begin
            req_off  = SPDR_OFS;
            req_wdat = tx_byte(idx);
         end
         ST_POLL: begin
            req_off = SPSR_OFS;
            req_we  = 1'b0;
         end
         ST_RX: begin
            req_off = SPDR_OFS;
            req_we  = 1'b0;
         end
         ST_CS_OFF: req_off = SSR_OFS;
         default: ;
      endcase

      if (bus_state) begin
         if (!launched) begin
            start      = 1'b1;
            launched_n = 1'b1;
         end else if (done) begin
            launched_n = 1'b0;
            case (state)
               ST_INIT:   if (init_step == 2'd2) state_n = ST_WAIT;
               ST_CS_ON:  state_n = ST_TX;
               ST_TX:     state_n = ST_POLL;
               ST_POLL: begin
                  if (!rdat[RFEMPTY])  state_n = ST_RX;
                  else if (poll_timeout) state_n = ST_CS_OFF;
               end
               ST_RX:     state_n = (idx == 3'd4) ? ST_CS_OFF : ST_TX;
               ST_CS_OFF: state_n = tmo_flag ? ST_WAIT : ST_PUB;
               default:   state_n = ST_INIT;
            endcase
         end
      end else if (state == ST_WAIT) begin
         if ((period_cnt == '0) && enable_i) state_n = ST_CS_ON;
      end else begin
         state_n = ST_WAIT;
      end
   end

`ifdef ACCEL_POLL_AVG_EN
   logic [9:0] acc_x, acc_y, acc_z;
   logic [9:0] sum_x, sum_y, sum_z;
   logic [1:0] avg_cnt;

   assign sum_x = acc_x + {{2{hx[7]}}, hx};
   assign sum_y = acc_y + {{2{hy[7]}}, hy};
   assign sum_z = acc_z + {{2{hz[7]}}, hz};
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         init_step      <= 2'd0;
         idx            <= 3'd0;
         poll_cnt       <= '0;
         tmo_flag       <= 1'b0;
         hx             <= 8'h00;
         hy             <= 8'h00;
         hz             <= 8'h00;
         period_cnt     <= '0;
         timeout_o      <= 1'b0;
         busy_o         <= 1'b0;
         sample_valid_o <= 1'b0;
         x_o            <= 8'h00;
         y_o            <= 8'h00;
         z_o            <= 8'h00;
`ifdef ACCEL_POLL_AVG_EN
         acc_x          <= 10'd0;
         acc_y          <= 10'd0;
         acc_z          <= 10'd0;
         avg_cnt        <= 2'd0;
`endif
      end else begin
         sample_valid_o <= 1'b0;
         busy_o <= (state_n inside {ST_CS_ON, ST_TX, ST_POLL, ST_RX, ST_CS_OFF});

         // Free-running period timer; disabling parks it at zero so re-enable starts at once.
         if (!enable_i || (period_cnt == CW'(PERIOD_CYC - 1))) period_cnt <= '0;
         else period_cnt <= period_cnt + CW'(1);

         if (done) begin
            case (state)
               ST_INIT:  init_step <= init_step + 2'd1;
               ST_CS_ON: begin
                  idx      <= 3'd0;
                  tmo_flag <= 1'b0;
               end
               ST_TX:    poll_cnt <= '0;
               ST_POLL: begin
                  if (rdat[RFEMPTY]) begin
                     poll_cnt <= poll_cnt + PW'(1);
                     if (poll_timeout) begin
                        timeout_o <= 1'b1;
                        tmo_flag  <= 1'b1;
`ifdef ACCEL_POLL_AVG_EN
                        acc_x   <= 10'd0;
                        acc_y   <= 10'd0;
                        acc_z   <= 10'd0;
                        avg_cnt <= 2'd0;
`endif
                     end
                  end
               end
               ST_RX: begin
                  case (idx)
                     3'd2:    hx <= rdat;
                     3'd3:    hy <= rdat;
                     3'd4:    hz <= rdat;
                     default: ;
                  endcase
                  idx <= idx + 3'd1;
               end
               default: ;
            endcase
         end

`ifdef ACCEL_POLL_AVG_EN
         if (pub_go) begin
            if (avg_cnt == 2'd3) begin
               x_o            <= sum_x[9:2];
               y_o            <= sum_y[9:2];
               z_o            <= sum_z[9:2];
               sample_valid_o <= 1'b1;
               acc_x          <= 10'd0;
               acc_y          <= 10'd0;
               acc_z          <= 10'd0;
               avg_cnt        <= 2'd0;
            end else begin
               acc_x   <= sum_x;
               acc_y   <= sum_y;
               acc_z   <= sum_z;
               avg_cnt <= avg_cnt + 2'd1;
            end
         end
`else
         if (pub_go) begin
            x_o            <= hx;
            y_o            <= hy;
            z_o            <= hz;
            sample_valid_o <= 1'b1;
         end
`endif
      end
   end

endmodule
